// File: rtl/fifo_reader_pkg.sv
// rtl/fifo_reader_pkg.sv - shared types and widths for the fifo_reader block
package fifo_reader_pkg;

   localparam int DATA_W = 8;
   localparam int CNT_W  = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      READ    = 2'd1,
      LATCH   = 2'd2,
      PRESENT = 2'd3
   } state_t;

endpackage

// File: rtl/fifo_reader_wrap_counter.sv
// rtl/fifo_reader_wrap_counter.sv - W-bit enable-increment counter, wraps to zero
// Asynchronous active-high clear.
module wrap_counter
   import fifo_reader_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - pops one FIFO word at a time and presents it on a valid/ready stream
// Optional macro FIFO_READER_CNT_EN adds the byte_count handshake counter.
module fifo_reader
   import fifo_reader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              fifo_empty,
   output logic              fifo_rd_en,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   input  logic              m_ready,
   output logic              busy
`ifdef FIFO_READER_CNT_EN
   ,
   output logic [CNT_W-1:0]  byte_count
`endif
);

   state_t            state_q, state_d;
   logic              rd_en_q, rd_en_d;
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q,  data_d;

   always_comb begin
      state_d = state_q;
      rd_en_d = 1'b0;
      valid_d = valid_q;
      data_d  = data_q;
      case (state_q)
         IDLE: begin
            if (en && !fifo_empty) begin
               state_d = READ;
               rd_en_d = 1'b1;
            end
         end
         // The FIFO samples the strobe at the end of READ; its word appears during LATCH.
         READ: begin
            state_d = LATCH;
         end
         LATCH: begin
            data_d  = fifo_data;
            valid_d = 1'b1;
            state_d = PRESENT;
         end
         PRESENT: begin
            if (m_ready) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rd_en_q <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         rd_en_q <= rd_en_d;
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign fifo_rd_en = rd_en_q;
   assign m_valid    = valid_q;
   assign m_data     = data_q;
   assign busy       = (state_q != IDLE);

`ifdef FIFO_READER_CNT_EN
   logic handshake;
   assign handshake = valid_q && m_ready;

   wrap_counter #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (handshake),
      .count (byte_count)
   );
`endif

endmodule

// File: doc/fifo_reader.md
# fifo_reader

Read-side controller for the 8-entry byte FIFO. It pops one word at a time through the FIFO's read port and absorbs the FIFO's one-cycle registered read latency. Each byte is presented to a downstream consumer on a valid/ready stream. It sits between the FIFO read interface and any byte sink, such as a serializer or display driver.

## Interface
- DATA_W, 8, width of FIFO words and stream data

- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  reset, asynchronous and active-high; clears all state immediately
- en  input  1  when high, the block may start new FIFO reads
- fifo_empty  input  1  FIFO empty flag (combinational from FIFO pointers)
- fifo_rd_en  output  1  read strobe to FIFO, registered, high for exactly one cycle per pop
- fifo_data  input  DATA_W  FIFO data_out, valid in the cycle after the cycle in which fifo_rd_en was high
- m_valid  output  1  stream data valid
- m_data  output  DATA_W  stream data
- m_ready  input  1  downstream accepts the byte when m_valid && m_ready at a rising edge
- busy  output  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, READ, LATCH, PRESENT.
- IDLE:
  - If en && !fifo_empty, go to READ and assert fifo_rd_en.
  - Otherwise stay in IDLE.
- READ:
  - fifo_rd_en is high for this cycle only. The FIFO samples it at the end of the cycle.
  - Unconditionally go to LATCH.
- LATCH:
  - fifo_data now holds the popped word. Register it into m_data.
  - Set m_valid and go to PRESENT.
- PRESENT:
  - Hold m_valid and m_data stable until m_ready is high.
  - On handshake, clear m_valid and go to IDLE.
- Only one read is ever outstanding. A second fifo_rd_en is never issued before the previous byte is handed off.
- Deasserting en mid-transfer does not abort it. The current byte completes through PRESENT, then the FSM parks in IDLE.
- fifo_empty is only sampled in IDLE. If it rises while in READ, LATCH or PRESENT, it has no effect.
- Reset asserted mid-operation: the FSM returns to IDLE immediately and any in-flight byte is discarded. No extra pop is issued after reset is released.
- m_ready is ignored outside PRESENT. m_valid never rises without a preceding pop.

## Timing
- Reset values: fifo_rd_en=0, m_valid=0, m_data=0, busy=0, FSM=IDLE. The optional counter resets to 0.
- Latency, counted from the first edge sampling en && !fifo_empty in IDLE:
  - fifo_rd_en is high in the following cycle (edge 1).
  - m_valid rises 2 cycles after that (edge 3).
- Minimum pop-to-pop period is 4 cycles, with m_ready held high.
- m_data changes only on the LATCH→PRESENT edge.
- busy is combinational from the state register, so it has no extra latency.

## Configuration
- Macro FIFO_READER_CNT_EN.
- When defined:
  - Adds output port byte_count [15:0].
  - byte_count increments by 1 on every m_valid && m_ready handshake.
  - It wraps from 16'hFFFF to 16'h0000 and is cleared by rst.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

## Structure
- Shared package fifo_reader_pkg contains:
  - the state enum (IDLE=2'd0, READ=2'd1, LATCH=2'd2, PRESENT=2'd3)
  - localparam DATA_W default
  - localparam CNT_W=16
- One sub-module is natural: wrap_counter, a CNT_W-bit enable-increment counter with async active-high clear. It is instantiated only under FIFO_READER_CNT_EN.
- The FSM and output register stay in fifo_reader.

## Test plan
- Reset: hold rst high, drive en=1 and fifo_empty=0.
  - Required: fifo_rd_en=0, m_valid=0, m_data=0, busy=0.
  - Asserting rst asynchronously mid-PRESENT drops m_valid before the next edge.
- Single byte: FIFO model preloaded with 8'hA5, en=1, m_ready=1.
  - fifo_rd_en is high for exactly 1 cycle.
  - m_valid goes high 2 cycles later with m_data=8'hA5.
  - The FIFO becomes empty and no further rd_en follows.
- Backpressure: preload 8'h3C and hold m_ready=0 for 10 cycles.
  - m_valid=1 and m_data=8'h3C stay stable throughout, with no second fifo_rd_en.
  - Raising m_ready completes the handshake in 1 cycle.
- Stream of eight: preload 8'h01..8'h08, m_ready=1.
  - Bytes arrive in order 01..08, 4 cycles apart.
  - Exactly 8 pops occur. With FIFO_READER_CNT_EN defined, byte_count=8.
- en dropped mid-transfer: clear en during LATCH with 2 bytes queued.
  - The current byte is delivered, then the FSM stays in IDLE.
  - Exactly 1 byte remains in the FIFO.
- Counter wrap (FIFO_READER_CNT_EN): force byte_count to 16'hFFFF, complete one handshake.
  - Required: byte_count=16'h0000.
